// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared definitions for the pipeline hazard controller:
//   - FSM state encodings (RUN / MEM_WAIT / REDIRECT)
//   - pipeline boundary indices into the 4-bit stall/flush vectors
//   - one-hot boundary masks used to build the stall/flush patterns
//   - default register-index width and internal counter width
// ---------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

  localparam int REG_ADDR_W_DEF = 5;
  localparam int CNT_W          = 8;

  // Boundary indices into stall_o / flush_o
  localparam int STG_IFID  = 0;
  localparam int STG_IDEX  = 1;
  localparam int STG_EXMEM = 2;
  localparam int STG_MEMWB = 3;

  localparam logic [3:0] BIT_IFID  = 4'(1 << STG_IFID);
  localparam logic [3:0] BIT_IDEX  = 4'(1 << STG_IDEX);
  localparam logic [3:0] BIT_EXMEM = 4'(1 << STG_EXMEM);
  localparam logic [3:0] BIT_MEMWB = 4'(1 << STG_MEMWB);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_REDIRECT = 2'd2
  } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_loaduse.sv
// ---------------------------------------------------------------------------
// pipe_loaduse_detect
// Pure combinational load-use hazard comparator. Flags when the load in EX
// writes a register that the instruction in ID actually reads. Register 0 is
// hard-wired zero, so a load targeting it never creates a dependency.
// Ports:
//   id_rs1_i / id_rs2_i            ID source register indices
//   id_rs1_used_i / id_rs2_used_i  ID instruction reads that source
//   ex_rd_i                        EX destination register index
//   ex_mem_read_i                  EX instruction is a load
//   loaduse_o                      hazard detected this cycle
// ---------------------------------------------------------------------------
module pipe_loaduse_detect
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_rs1_used_i,
  input  logic                  id_rs2_used_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_mem_read_i,
  output logic                  loaduse_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit   = id_rs1_used_i && (id_rs1_i == ex_rd_i);
  assign rs2_hit   = id_rs2_used_i && (id_rs2_i == ex_rd_i);
  assign loaduse_o = ex_mem_read_i && (ex_rd_i != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central stall/flush controller for the 5-stage integer pipeline.
// Resolves, in fixed priority: data-memory wait, trap redirect, branch
// redirect, load-use hazard, instruction-fetch wait / post-redirect bubbles.
// A small FSM inserts fetch bubbles after a redirect and runs a watchdog on
// data-memory waits.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   id_rs*/ex_rd/ex_mem_read  load-use detection inputs
//   ex_br_taken_i, trap_i   redirect requests
//   imem_ready_i            fetch data valid
//   dmem_req_i, dmem_ready_i  data-memory handshake
//   pc_stall_o              hold PC
//   stall_o / flush_o       per-boundary controls (bit0 IF/ID .. bit3 MEM/WB)
//   state_o                 FSM state (0 RUN, 1 MEM_WAIT, 2 REDIRECT)
//   mem_timeout_o           one-cycle watchdog pulse
//   perf_stall_cnt_o        cycles with pc_stall_o set (optional)
//   perf_flush_cnt_o        cycles with any flush_o bit set (optional)
//
// Build option: define PIPE_PERF_CNT_EN to instantiate the saturating
// performance counters; otherwise the perf ports are tied to zero.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W       = REG_ADDR_W_DEF,
  parameter int REDIRECT_BUBBLES = 1,
  parameter int MEM_TIMEOUT      = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_rs1_used_i,
  input  logic                  id_rs2_used_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_mem_read_i,
  input  logic                  ex_br_taken_i,
  input  logic                  trap_i,
  input  logic                  imem_ready_i,
  input  logic                  dmem_req_i,
  input  logic                  dmem_ready_i,
  output logic                  pc_stall_o,
  output logic [3:0]            stall_o,
  output logic [3:0]            flush_o,
  output logic [1:0]            state_o,
  output logic                  mem_timeout_o,
  output logic [31:0]           perf_stall_cnt_o,
  output logic [31:0]           perf_flush_cnt_o
);

  localparam logic [CNT_W-1:0] BUBBLES_INIT = CNT_W'(REDIRECT_BUBBLES);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL  = CNT_W'(MEM_TIMEOUT);

  hz_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;

  logic       loaduse;
  logic       timeout_hit;
  logic       memwait;
  logic       redirect_ev;
  logic       pc_stall_c;
  logic [3:0] stall_c;
  logic [3:0] flush_c;

  pipe_loaduse_detect #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_loaduse (
    .id_rs1_i     (id_rs1_i),
    .id_rs2_i     (id_rs2_i),
    .id_rs1_used_i(id_rs1_used_i),
    .id_rs2_used_i(id_rs2_used_i),
    .ex_rd_i      (ex_rd_i),
    .ex_mem_read_i(ex_mem_read_i),
    .loaduse_o    (loaduse)
  );

  // The watchdog fires on the cycle the wait counter reaches the limit; that
  // cycle the memory stall is dropped so the pipeline can take the abort.
  assign timeout_hit = (state_q == ST_MEM_WAIT) && (MEM_TIMEOUT != 0) &&
                       (cnt_q == TIMEOUT_VAL);
  assign memwait     = dmem_req_i && !dmem_ready_i && !timeout_hit;
  assign redirect_ev = trap_i || ex_br_taken_i;

  // Fixed-priority stall/flush selection. Every pattern keeps stall and
  // flush disjoint per boundary because the stage registers let Stall win.
  always_comb begin
    pc_stall_c = 1'b0;
    stall_c    = '0;
    flush_c    = '0;
    if (memwait) begin
      pc_stall_c = 1'b1;
      stall_c    = BIT_IFID | BIT_IDEX | BIT_EXMEM;
      flush_c    = BIT_MEMWB;
    end else if (trap_i) begin
      flush_c    = BIT_IFID | BIT_IDEX | BIT_EXMEM;
    end else if (ex_br_taken_i) begin
      flush_c    = BIT_IFID | BIT_IDEX;
    end else if (loaduse) begin
      pc_stall_c = 1'b1;
      stall_c    = BIT_IFID;
      flush_c    = BIT_IDEX;
    end else if (!imem_ready_i || (state_q == ST_REDIRECT)) begin
      pc_stall_c = !imem_ready_i;
      flush_c    = BIT_IFID;
    end
  end

  // Outputs are forced low while reset is held so nothing leaks out of an
  // uninitialised or stale state register.
  assign pc_stall_o    = rst_n && pc_stall_c;
  assign stall_o       = rst_n ? stall_c : 4'b0000;
  assign flush_o       = rst_n ? flush_c : 4'b0000;
  assign state_o       = rst_n ? state_q : ST_RUN;
  assign mem_timeout_o = rst_n && timeout_hit;

  // Controller FSM. cnt_q is shared: it counts wait cycles in MEM_WAIT and
  // remaining fetch bubbles in REDIRECT. A redirect request while already in
  // REDIRECT (trap from an older instruction) restarts the bubble window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (memwait) begin
            state_q <= ST_MEM_WAIT;
            cnt_q   <= CNT_W'(1);
          end else if (redirect_ev && (REDIRECT_BUBBLES > 0)) begin
            state_q <= ST_REDIRECT;
            cnt_q   <= BUBBLES_INIT;
          end
        end
        ST_MEM_WAIT: begin
          if (memwait) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
          end
        end
        ST_REDIRECT: begin
          if (!memwait) begin
            if (redirect_ev) begin
              cnt_q <= BUBBLES_INIT;
            end else if (cnt_q <= CNT_W'(1)) begin
              state_q <= ST_RUN;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
        end
        default: begin
          state_q <= ST_RUN;
          cnt_q   <= '0;
        end
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;

  // Saturating event counters; they stick at all-ones rather than wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (pc_stall_o && !(&perf_stall_q)) perf_stall_q <= perf_stall_q + 32'd1;
      if ((|flush_o) && !(&perf_flush_q)) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_stall_cnt_o = rst_n ? perf_stall_q : 32'd0;
  assign perf_flush_cnt_o = rst_n ? perf_flush_q : 32'd0;
`else
  assign perf_stall_cnt_o = 32'd0;
  assign perf_flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Self-checking bench for pipe_hazard_ctrl (REDIRECT_BUBBLES=2,
// MEM_TIMEOUT=8). Directed scenarios plus a randomized run compared against
// a behavioural model of the hazard rules. Observed outputs are packed as
// {pc_stall, stall[3:0], flush[3:0], state[1:0], mem_timeout}.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int AW  = 5;
  localparam int BUB = 2;
  localparam int TMO = 8;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] id_rs1, id_rs2, ex_rd;
  logic          id_rs1_used, id_rs2_used, ex_mem_read;
  logic          ex_br_taken, trap, imem_ready, dmem_req, dmem_ready;
  logic          pc_stall, mem_timeout;
  logic [3:0]    stall, flush;
  logic [1:0]    state;
  logic [31:0]   perf_stall_cnt, perf_flush_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  pipe_hazard_ctrl #(
    .REG_ADDR_W      (AW),
    .REDIRECT_BUBBLES(BUB),
    .MEM_TIMEOUT     (TMO)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs1_i        (id_rs1),
    .id_rs2_i        (id_rs2),
    .id_rs1_used_i   (id_rs1_used),
    .id_rs2_used_i   (id_rs2_used),
    .ex_rd_i         (ex_rd),
    .ex_mem_read_i   (ex_mem_read),
    .ex_br_taken_i   (ex_br_taken),
    .trap_i          (trap),
    .imem_ready_i    (imem_ready),
    .dmem_req_i      (dmem_req),
    .dmem_ready_i    (dmem_ready),
    .pc_stall_o      (pc_stall),
    .stall_o         (stall),
    .flush_o         (flush),
    .state_o         (state),
    .mem_timeout_o   (mem_timeout),
    .perf_stall_cnt_o(perf_stall_cnt),
    .perf_flush_cnt_o(perf_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] obs();
    return {pc_stall, stall, flush, state, mem_timeout};
  endfunction

  task automatic set_idle();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_mem_read = 1'b0;
    ex_br_taken = 1'b0; trap = 1'b0; imem_ready = 1'b1;
    dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_idle();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_idle();
    trap = 1'b1; ex_br_taken = 1'b1; dmem_req = 1'b1; imem_ready = 1'b0;
    @(negedge clk);
    tests_run++;
    if (obs() !== 12'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_hold: got %b expected %b", obs(), 12'b0);
    end
    tests_run++;
    if ({perf_stall_cnt, perf_flush_cnt} !== 64'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_perf: got %0d/%0d expected 0/0", perf_stall_cnt, perf_flush_cnt);
    end
    tick();
    rst_n = 1'b1;
    set_idle();
    @(negedge clk);
    tests_run++;
    if (obs() !== 12'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_idle: got %b expected %b", obs(), 12'b0);
    end
    tick();
  endtask

  task automatic test_load_use();
    logic [11:0] lu_pat;
    lu_pat = {1'b1, 4'b0001, 4'b0010, 2'b00, 1'b0};
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs2_used = 1'b1;
    id_rs1 = 5'd3; id_rs1_used = 1'b1;
    @(negedge clk);
    tests_run++;
    if (obs() !== lu_pat) begin
      tests_failed++;
      $display("[TB] FAIL loaduse_rs2: got %b expected %b", obs(), lu_pat);
    end
    tick();
    ex_rd = 5'd0; id_rs2 = 5'd0; id_rs1 = 5'd0;
    @(negedge clk);
    tests_run++;
    if (obs() !== 12'b0) begin
      tests_failed++;
      $display("[TB] FAIL loaduse_rd0: got %b expected %b", obs(), 12'b0);
    end
    tick();
    ex_rd = 5'd9; id_rs1 = 5'd9; id_rs1_used = 1'b0; id_rs2 = 5'd4;
    @(negedge clk);
    tests_run++;
    if (obs() !== 12'b0) begin
      tests_failed++;
      $display("[TB] FAIL loaduse_unused_src: got %b expected %b", obs(), 12'b0);
    end
    tick();
    id_rs1_used = 1'b1;
    @(negedge clk);
    tests_run++;
    if (obs() !== lu_pat) begin
      tests_failed++;
      $display("[TB] FAIL loaduse_rs1: got %b expected %b", obs(), lu_pat);
    end
    tick();
    ex_mem_read = 1'b0;
    @(negedge clk);
    tests_run++;
    if (obs() !== 12'b0) begin
      tests_failed++;
      $display("[TB] FAIL loaduse_not_load: got %b expected %b", obs(), 12'b0);
    end
    tick();
  endtask

  task automatic test_branch_redirect();
    logic [11:0] exp;
    do_reset();
    ex_br_taken = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 0)      exp = {1'b0, 4'b0000, 4'b0011, 2'b00, 1'b0};
      else if (c < 3)  exp = {1'b0, 4'b0000, 4'b0001, 2'b10, 1'b0};
      else             exp = 12'b0;
      @(negedge clk);
      tests_run++;
      if (obs() !== exp) begin
        tests_failed++;
        $display("[TB] FAIL branch_cycle%0d: got %b expected %b", c, obs(), exp);
      end
      tick();
      ex_br_taken = 1'b0;
    end
  endtask

  task automatic test_data_wait();
    logic [11:0] exp;
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c == 4) dmem_ready = 1'b1;
      if (c == 5) begin dmem_req = 1'b0; dmem_ready = 1'b0; end
      if (c < 4)       exp = {1'b1, 4'b0111, 4'b1000, (c == 0) ? 2'b00 : 2'b01, 1'b0};
      else if (c == 4) exp = {1'b0, 4'b0000, 4'b0000, 2'b01, 1'b0};
      else             exp = 12'b0;
      @(negedge clk);
      tests_run++;
      if (obs() !== exp) begin
        tests_failed++;
        $display("[TB] FAIL dwait_cycle%0d: got %b expected %b", c, obs(), exp);
      end
      tick();
    end
  endtask

  task automatic test_watchdog();
    logic [11:0] exp;
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c == 9) dmem_req = 1'b0;
      if (c < 8)       exp = {1'b1, 4'b0111, 4'b1000, (c == 0) ? 2'b00 : 2'b01, 1'b0};
      else if (c == 8) exp = {1'b0, 4'b0000, 4'b0000, 2'b01, 1'b1};
      else             exp = 12'b0;
      @(negedge clk);
      tests_run++;
      if (obs() !== exp) begin
        tests_failed++;
        $display("[TB] FAIL watchdog_cycle%0d: got %b expected %b", c, obs(), exp);
      end
      tick();
    end
  endtask

  task automatic test_priority();
    logic [11:0] exp;
    do_reset();
    trap = 1'b1; ex_br_taken = 1'b1;
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
    exp = {1'b0, 4'b0000, 4'b0111, 2'b00, 1'b0};
    @(negedge clk);
    tests_run++;
    if (obs() !== exp) begin
      tests_failed++;
      $display("[TB] FAIL prio_trap: got %b expected %b", obs(), exp);
    end
    tick();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    exp = {1'b1, 4'b0111, 4'b1000, 2'b10, 1'b0};
    @(negedge clk);
    tests_run++;
    if (obs() !== exp) begin
      tests_failed++;
      $display("[TB] FAIL prio_memwait: got %b expected %b", obs(), exp);
    end
    tests_run++;
    if ((stall & flush) !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL prio_overlap: got %b expected 0000", stall & flush);
    end
    tick();
  endtask

  task automatic test_reset_mid_redirect();
    do_reset();
    ex_br_taken = 1'b1;
    tick();
    ex_br_taken = 1'b0;
    @(negedge clk);
    tests_run++;
    if (state !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL midred_enter: got state %0d expected 2", state);
    end
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    tests_run++;
    if (obs() !== 12'b0) begin
      tests_failed++;
      $display("[TB] FAIL midred_in_reset: got %b expected %b", obs(), 12'b0);
    end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({obs(), perf_stall_cnt, perf_flush_cnt} !== 76'd0) begin
      tests_failed++;
      $display("[TB] FAIL midred_after: got %b perf %0d/%0d expected all 0", obs(), perf_stall_cnt, perf_flush_cnt);
    end
    tick();
  endtask

  // Randomized run against a rule-level model: mode 0 running, 1 waiting on
  // data memory, 2 inserting fetch bubbles after a redirect.
  task automatic test_random();
    int          m_mode, m_wait_len, m_bubbles_left;
    longint      m_pstall, m_pflush;
    bit          lu, tmo, mw, e_pc;
    logic [3:0]  e_st, e_fl;
    logic [11:0] exp;
    logic [63:0] exp_perf;
    do_reset();
    m_mode = 0; m_wait_len = 0; m_bubbles_left = 0; m_pstall = 0; m_pflush = 0;
    for (int n = 0; n < 800; n++) begin
      rst_n       = ($urandom_range(0, 79) != 0);
      id_rs1      = AW'($urandom_range(0, 3));
      id_rs2      = AW'($urandom_range(0, 3));
      ex_rd       = AW'($urandom_range(0, 3));
      id_rs1_used = $urandom_range(0, 1) == 1;
      id_rs2_used = $urandom_range(0, 1) == 1;
      ex_mem_read = $urandom_range(0, 2) == 0;
      trap        = $urandom_range(0, 15) == 0;
      ex_br_taken = $urandom_range(0, 9) == 0;
      imem_ready  = $urandom_range(0, 6) != 0;
      if (dmem_req && !dmem_ready) dmem_req = $urandom_range(0, 9) != 0;
      else                         dmem_req = $urandom_range(0, 3) == 0;
      dmem_ready  = $urandom_range(0, 3) == 0;

      lu  = ex_mem_read && (ex_rd != 0) &&
            ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
      tmo = (m_mode == 1) && (TMO != 0) && (m_wait_len == TMO);
      mw  = dmem_req && !dmem_ready && !tmo;
      e_pc = 1'b0; e_st = 4'b0000; e_fl = 4'b0000;
      if (!rst_n) begin
        e_pc = 1'b0;
      end else if (mw) begin
        e_pc = 1'b1; e_st = 4'b0111; e_fl = 4'b1000;
      end else if (trap) begin
        e_fl = 4'b0111;
      end else if (ex_br_taken) begin
        e_fl = 4'b0011;
      end else if (lu) begin
        e_pc = 1'b1; e_st = 4'b0001; e_fl = 4'b0010;
      end else if (!imem_ready || m_mode == 2) begin
        e_pc = !imem_ready; e_fl = 4'b0001;
      end
      exp = {e_pc, e_st, e_fl, rst_n ? 2'(m_mode) : 2'b00, rst_n && tmo};
`ifdef PIPE_PERF_CNT_EN
      exp_perf = rst_n ? {m_pstall[31:0], m_pflush[31:0]} : 64'd0;
`else
      exp_perf = 64'd0;
`endif
      @(negedge clk);
      tests_run++;
      if (obs() !== exp) begin
        tests_failed++;
        $display("[TB] FAIL random_%0d: got %b expected %b", n, obs(), exp);
      end
      tests_run++;
      if ({perf_stall_cnt, perf_flush_cnt} !== exp_perf) begin
        tests_failed++;
        $display("[TB] FAIL random_perf_%0d: got %0d/%0d expected %0d/%0d", n,
                 perf_stall_cnt, perf_flush_cnt, exp_perf[63:32], exp_perf[31:0]);
      end

      if (!rst_n) begin
        m_mode = 0; m_wait_len = 0; m_bubbles_left = 0; m_pstall = 0; m_pflush = 0;
      end else begin
        if (e_pc && m_pstall < 64'hFFFF_FFFF) m_pstall = m_pstall + 1;
        if (e_fl != 0 && m_pflush < 64'hFFFF_FFFF) m_pflush = m_pflush + 1;
        if (m_mode == 0) begin
          if (mw) begin
            m_mode = 1; m_wait_len = 1;
          end else if ((trap || ex_br_taken) && BUB > 0) begin
            m_mode = 2; m_bubbles_left = BUB;
          end
        end else if (m_mode == 1) begin
          if (mw) m_wait_len = m_wait_len + 1;
          else begin m_mode = 0; m_wait_len = 0; end
        end else if (!mw) begin
          if (trap || ex_br_taken)     m_bubbles_left = BUB;
          else if (m_bubbles_left == 1) m_mode = 0;
          else                          m_bubbles_left = m_bubbles_left - 1;
        end
      end
      tick();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle();
    test_reset();
    test_load_use();
    test_branch_redirect();
    test_data_wait();
    test_watchdog();
    test_priority();
    test_reset_mid_redirect();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
